// File: rtl/led7seg_pkg.sv
// Shared definitions for the 7-segment scan controller.
// Contents:
//   state_t           scan FSM states (ST_BLANK, ST_DRIVE)
//   SEG_0..SEG_F      segment codes {a,b,c,d,e,f,g}, active-high
//   SEG_OFF           all segments dark
package led7seg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_0   = 7'h7E;
  localparam logic [6:0] SEG_1   = 7'h30;
  localparam logic [6:0] SEG_2   = 7'h6D;
  localparam logic [6:0] SEG_3   = 7'h79;
  localparam logic [6:0] SEG_4   = 7'h33;
  localparam logic [6:0] SEG_5   = 7'h5B;
  localparam logic [6:0] SEG_6   = 7'h5F;
  localparam logic [6:0] SEG_7   = 7'h70;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h7B;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h1F;
  localparam logic [6:0] SEG_C   = 7'h4E;
  localparam logic [6:0] SEG_D   = 7'h3D;
  localparam logic [6:0] SEG_E   = 7'h4F;
  localparam logic [6:0] SEG_F   = 7'h47;

endpackage

// File: rtl/led7seg_decode.sv
// Combinational hex nibble to 7-segment decoder.
// Ports:
//   nibble  in  4  hex digit
//   seg     out 7  segments {a,b,c,d,e,f,g}, active-high
module led7seg_decode
  import led7seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/led7seg_scan_ctrl.sv
// Time-multiplexed scan controller for N_DIGITS common-cathode 7-segment
// digits sharing one decoder. Each digit gets BLANK_CYCLES of dead time
// followed by DRIVE_CYCLES lit. A shadow value loaded through a ready/load
// handshake is committed to the displayed value only at frame wrap.
// Optional build macro: LED7SEG_LZB_EN enables leading-zero blanking.
// Ports:
//   clk         in   1           system clock (rising edge)
//   rst_n       in   1           asynchronous active-low reset
//   load        in   1           capture value when load && ready
//   value       in   4*N_DIGITS  hex nibbles, nibble 0 = rightmost digit
//   ready       out  1           shadow register free
//   seg         out  7           segments {a..g}, active-high, registered
//   dig_en      out  N_DIGITS    digit commons, active-low, registered
//   frame_done  out  1           one-clock pulse on frame wrap, registered
module led7seg_scan_ctrl
  import led7seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DRIVE_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  output logic                  ready,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   dig_en,
  output logic                  frame_done
);

  localparam int MAX_CYC = (BLANK_CYCLES > DRIVE_CYCLES) ? BLANK_CYCLES : DRIVE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC);
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRV_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] active;
  logic [4*N_DIGITS-1:0] shadow;
  logic                  pending;

  logic [3:0] cur_nibble;
  logic [6:0] cur_seg;
  logic       lit;

  assign ready      = ~pending;
  assign cur_nibble = active[{idx, 2'b00} +: 4];

  led7seg_decode u_decode (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

`ifdef LED7SEG_LZB_EN
  // A digit is dark when it and all more-significant nibbles are zero;
  // digit 0 always shows so a zero value still reads "0".
  always_comb begin
    lit = 1'b1;
    if ((idx != '0) && ((active >> {idx, 2'b00}) == '0))
      lit = 1'b0;
  end
`else
  assign lit = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      idx        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      seg        <= SEG_OFF;
      dig_en     <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // Load and commit are mutually exclusive on pending, so a load that
      // coincides with a commit is dropped and one on an idle boundary
      // waits for the following boundary.
      if (load && !pending) begin
        shadow  <= value;
        pending <= 1'b1;
      end

      case (state)
        ST_BLANK: begin
          if (cnt == BLK_LAST) begin
            state  <= ST_DRIVE;
            cnt    <= '0;
            seg    <= lit ? cur_seg : SEG_OFF;
            dig_en <= lit ? ~(N_DIGITS'(1) << idx) : '1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt == DRV_LAST) begin
            state  <= ST_BLANK;
            cnt    <= '0;
            seg    <= SEG_OFF;
            dig_en <= '1;
            if (idx == IDX_LAST) begin
              idx        <= '0;
              frame_done <= 1'b1;
              if (pending) begin
                active  <= shadow;
                pending <= 1'b0;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_BLANK;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led7seg_scan_ctrl.sv
// Directed self-checking bench for led7seg_scan_ctrl with N_DIGITS=4,
// DRIVE_CYCLES=8, BLANK_CYCLES=2 (40-clock frame). Edge numbering: edge 0 is
// the first rising edge after reset release; digit d of frame f lights after
// edge 1+10*d+40*f and the frame wraps on edge 39+40*f.
// Honours LED7SEG_LZB_EN for the leading-zero blanking expectations.
module tb_led7seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic        ready;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic        frame_done;

  int n_checks;
  int n_fail;
  int edge_no;

  led7seg_scan_ctrl #(
    .N_DIGITS     (4),
    .DRIVE_CYCLES (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .ready      (ready),
    .seg        (seg),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    edge_no++;
  endtask

  task automatic run_to(input int e);
    while (edge_no < e) cyc();
  endtask

  task automatic chk_digit(input string tag, input logic [3:0] en, input logic [6:0] sg);
    chk({tag, "_dig_en"}, 32'(dig_en), 32'(en));
    chk({tag, "_seg"}, 32'(seg), 32'(sg));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = 16'h0;
    edge_no  = -1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'h00);
    chk("rst_dig_en", 32'(dig_en), 32'hF);
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    rst_n = 1'b1;

    run_to(0);
    chk_digit("blank0", 4'b1111, 7'h00);
    run_to(1);
    chk_digit("first_d0", 4'b1110, 7'h7E);

    // Load 1234 at edge 5
    run_to(4);
    load = 1'b1; value = 16'h1234;
    run_to(5);
    load = 1'b0;
    chk("ready_after_load", 32'(ready), 32'h0);
    run_to(9);
    chk_digit("d0_end_blank", 4'b1111, 7'h00);

    // Load while not ready is dropped
    load = 1'b1; value = 16'hBEEF;
    run_to(10);
    load = 1'b0;
    chk("ready_still_low", 32'(ready), 32'h0);
    run_to(11);
    chk_digit("old_d1", 4'b1101, 7'h7E);

    run_to(38);
    chk("fd_before_wrap", 32'(frame_done), 32'h0);
    run_to(39);
    chk("fd_wrap1", 32'(frame_done), 32'h1);
    chk("ready_after_commit", 32'(ready), 32'h1);
    run_to(40);
    chk("fd_one_clock", 32'(frame_done), 32'h0);

    run_to(41);
    chk_digit("f1_d0", 4'b1110, 7'h33);
    // Reload BEEF now that ready is high
    load = 1'b1; value = 16'hBEEF;
    run_to(45);
    load = 1'b0;
    chk("ready_low_beef", 32'(ready), 32'h0);
    run_to(49);
    chk_digit("f1_gap", 4'b1111, 7'h00);
    run_to(51);
    chk_digit("f1_d1", 4'b1101, 7'h79);
    run_to(61);
    chk_digit("f1_d2", 4'b1011, 7'h6D);
    run_to(71);
    chk_digit("f1_d3", 4'b0111, 7'h30);
    run_to(79);
    chk("fd_wrap2", 32'(frame_done), 32'h1);

    run_to(81);
    chk_digit("f2_d0", 4'b1110, 7'h47);
    run_to(91);
    chk_digit("f2_d1", 4'b1101, 7'h4F);
    run_to(101);
    chk_digit("f2_d2", 4'b1011, 7'h4F);
    run_to(111);
    chk_digit("f2_d3", 4'b0111, 7'h1F);

    // Load sampled on the wrap edge with nothing pending
    run_to(118);
    load = 1'b1; value = 16'h5A09;
    run_to(119);
    load = 1'b0;
    chk("fd_wrap3", 32'(frame_done), 32'h1);
    chk("ready_boundary_load", 32'(ready), 32'h0);
    run_to(121);
    chk_digit("f3_d0_still_old", 4'b1110, 7'h47);
    run_to(159);
    chk("ready_after_commit2", 32'(ready), 32'h1);
    run_to(161);
    chk_digit("f4_d0", 4'b1110, 7'h7B);
    run_to(171);
    chk_digit("f4_d1", 4'b1101, 7'h7E);
    run_to(181);
    chk_digit("f4_d2", 4'b1011, 7'h77);

    // Asynchronous reset in the middle of digit 2
    #2;
    rst_n = 1'b0;
    #1;
    chk_digit("async_rst", 4'b1111, 7'h00);
    chk("async_rst_ready", 32'(ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    edge_no = -1;
    run_to(1);
    chk_digit("post_rst_d0", 4'b1110, 7'h7E);
    run_to(11);
    chk_digit("post_rst_d1_cleared", 4'b1101, 7'h7E);

    // Leading-zero blanking
    run_to(14);
    load = 1'b1; value = 16'h0070;
    run_to(15);
    load = 1'b0;
    run_to(41);
    chk_digit("lzb_d0", 4'b1110, 7'h7E);
    run_to(51);
    chk_digit("lzb_d1", 4'b1101, 7'h70);
    run_to(61);
`ifdef LED7SEG_LZB_EN
    chk_digit("lzb_d2", 4'b1111, 7'h00);
`else
    chk_digit("lzb_d2", 4'b1011, 7'h7E);
`endif
    run_to(71);
`ifdef LED7SEG_LZB_EN
    chk_digit("lzb_d3", 4'b1111, 7'h00);
`else
    chk_digit("lzb_d3", 4'b0111, 7'h7E);
`endif
    run_to(79);
    chk("fd_lzb_wrap", 32'(frame_done), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
